// File: rtl/pix_capture_writer.sv
// Pixel-channel capture controller: filters one channel out of an interleaved
// sample stream, decimates it and writes the kept samples into a capture RAM.
module pix_capture_writer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CH_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              trig,
  input  logic              abort,
  input  logic [CH_W-1:0]   sel_ch,
  input  logic [7:0]        decim,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  output logic              bram_we,
  output logic              bram_en_a,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  localparam logic [ADDR_W:0] LAST_WORD = {1'b0, {ADDR_W{1'b1}}};

  state_t          state;
  logic [CH_W-1:0] sel_lat;
  logic [7:0]      decim_lat;
  logic [7:0]      dec_cnt;
  logic            eligible;
  logic            match;
  logic            step;
  logic            vld_p0;

  // The trigger cycle itself already counts as capture time.
  always_comb begin
    eligible = (state == CAPTURE) || ((state == ARMED) && trig);
    match    = in_valid && (in_ch == sel_lat);
    step     = !abort && eligible && match;
    vld_p0   = step && (dec_cnt == 8'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      bram_we      <= 1'b0;
      bram_en_a    <= 1'b0;
      bram_addr    <= '0;
      bram_wr_data <= '0;
      wr_count     <= '0;
      sel_lat      <= '0;
      decim_lat    <= '0;
      dec_cnt      <= '0;
    end else begin
      // p0 -> p1: accepted sample becomes the registered RAM write
      bram_we   <= vld_p0;
      bram_en_a <= vld_p0;
      if (vld_p0) begin
        bram_addr    <= wr_count[ADDR_W-1:0];
        bram_wr_data <= in_data;
        wr_count     <= wr_count + 1'b1;
      end
      if (step) begin
        dec_cnt <= (dec_cnt == decim_lat) ? 8'd0 : dec_cnt + 8'd1;
      end

      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (arm) begin
              state     <= ARMED;
              busy      <= 1'b1;
              done      <= 1'b0;
              sel_lat   <= sel_ch;
              decim_lat <= decim;
              wr_count  <= '0;
              dec_cnt   <= '0;
            end
          end
          ARMED: begin
            if (trig) state <= CAPTURE;
          end
          CAPTURE: begin
            if (vld_p0 && (wr_count == LAST_WORD)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pix_capture_writer.sv
// Randomized bench for pix_capture_writer against a list-level capture model.
module tb_pix_capture_writer;

  logic        clk;
  logic        rst;
  logic        arm;
  logic        trig;
  logic        abort;
  logic [7:0]  sel_ch;
  logic [7:0]  decim;
  logic        in_valid;
  logic [7:0]  in_ch;
  logic [31:0] in_data;
  logic        bram_we;
  logic        bram_en_a;
  logic [9:0]  bram_addr;
  logic [31:0] bram_wr_data;
  logic        busy;
  logic        done;
  logic [10:0] wr_count;

  int checks = 0;
  int errors = 0;

  // Reference: kept sample k of a capture is matching sample number k*(decim+1)
  // after the trigger, stored at address k, until the RAM is full.
  bit          m_armed, m_live, m_done, m_we;
  logic [7:0]  m_sel;
  int          m_dec, m_seen, m_cnt;
  logic [9:0]  m_addr;
  logic [31:0] m_data;

  pix_capture_writer #(.ADDR_W(10), .DATA_W(32), .CH_W(8)) dut (
    .clk(clk), .rst(rst), .arm(arm), .trig(trig), .abort(abort),
    .sel_ch(sel_ch), .decim(decim), .in_valid(in_valid), .in_ch(in_ch),
    .in_data(in_data), .bram_we(bram_we), .bram_en_a(bram_en_a),
    .bram_addr(bram_addr), .bram_wr_data(bram_wr_data), .busy(busy),
    .done(done), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_live = 0; m_done = 0; m_we = 0;
    m_sel = 8'd0; m_dec = 0; m_seen = 0; m_cnt = 0;
    m_addr = 10'd0; m_data = 32'd0;
  endtask

  task automatic cyc(input bit a, input bit t, input bit ab, input bit v,
                     input logic [7:0] ch, input logic [31:0] d);
    bit elig;
    arm = a; trig = t; abort = ab; in_valid = v; in_ch = ch; in_data = d;
    elig = !ab && (m_live || (m_armed && t));
    m_we = 0;
    if (elig && v && ch == m_sel) begin
      if (m_seen % (m_dec + 1) == 0) begin
        m_we = 1; m_addr = m_cnt[9:0]; m_data = d; m_cnt++;
      end
      m_seen++;
    end
    if (ab) begin
      m_armed = 0; m_live = 0; m_done = 0;
    end else if (!m_armed && a) begin
      m_armed = 1; m_live = 0; m_done = 0;
      m_sel = sel_ch; m_dec = int'(decim); m_seen = 0; m_cnt = 0;
    end else if (m_armed && !m_live && t) begin
      m_live = 1;
    end
    if (m_live && m_cnt == 1024) begin
      m_armed = 0; m_live = 0; m_done = 1;
    end
    @(posedge clk);
    #1;
    check("we", 64'(bram_we), 64'(m_we));
    check("en", 64'(bram_en_a), 64'(m_we));
    check("busy", 64'(busy), 64'(m_armed));
    check("done", 64'(done), 64'(m_done));
    check("wr_count", 64'(wr_count), 64'(m_cnt));
    check("addr", 64'(bram_addr), 64'(m_addr));
    check("data", 64'(bram_wr_data), 64'(m_data));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"}, 64'(bram_we), 64'd0);
    check({tag, "_en"}, 64'(bram_en_a), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_cnt"}, 64'(wr_count), 64'd0);
    check({tag, "_addr"}, 64'(bram_addr), 64'd0);
    check({tag, "_data"}, 64'(bram_wr_data), 64'd0);
  endtask

  initial begin
    rst = 1'b1; arm = 0; trig = 0; abort = 0; sel_ch = 0; decim = 0;
    in_valid = 0; in_ch = 0; in_data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Basic capture: channel 5 out of 0..7 round-robin, no decimation.
    sel_ch = 8'd5; decim = 8'd0;
    cyc(1, 0, 0, 0, 8'd0, 32'd0);
    for (int i = 0; i < 8300 && !m_done; i++)
      cyc(0, (i == 0) ? 1'b1 : 1'($urandom % 2), 0, 1, 8'(i % 8), 32'(i));
    check("basic_done", 64'(done), 64'd1);
    check("basic_cnt", 64'(wr_count), 64'd1024);
    check("basic_busy", 64'(busy), 64'd0);
    check("basic_last_addr", 64'(bram_addr), 64'd1023);
    check("basic_last_data", 64'(bram_wr_data), 64'd8189);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 1, 8'd5, $urandom);

    // Re-arm from DONE on channel 9; arm pulses and input changes mid-capture.
    sel_ch = 8'd9; decim = 8'd0;
    cyc(1, 0, 0, 1, 8'd9, $urandom);
    for (int i = 0; i < 20000 && !m_done; i++) begin
      sel_ch = 8'($urandom % 16); decim = 8'($urandom % 4);
      cyc(1'($urandom % 16 == 0), (i == 0) ? 1'b1 : 1'($urandom % 2), 0,
          1'($urandom % 4 != 0), 8'(8 + $urandom % 4), $urandom);
    end
    check("rearm_done", 64'(done), 64'd1);
    check("rearm_cnt", 64'(wr_count), 64'd1024);

    // Decimation by 4 on a pure channel-5 stream.
    sel_ch = 8'd5; decim = 8'd3;
    cyc(1, 0, 0, 0, 8'd0, 32'd0);
    for (int i = 0; i < 4200 && !m_done; i++)
      cyc(0, (i == 0) ? 1'b1 : 1'b0, 0, 1, 8'd5, 32'(i));
    check("decim_cnt", 64'(wr_count), 64'd1024);
    check("decim_last_data", 64'(bram_wr_data), 64'd4092);

    // Abort after 100 writes.
    sel_ch = 8'd2; decim = 8'd0;
    cyc(1, 0, 0, 0, 8'd0, 32'd0);
    for (int i = 0; i < 200 && m_cnt < 100; i++)
      cyc(0, (i == 0) ? 1'b1 : 1'b0, 0, 1, 8'd2, 32'(1000 + i));
    cyc(0, 0, 1, 1, 8'd2, 32'hDEAD);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_cnt", 64'(wr_count), 64'd100);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 1, 8'd2, $urandom);
    cyc(1, 0, 0, 0, 8'd0, 32'd0);
    check("abort_rearm_cnt", 64'(wr_count), 64'd0);
    cyc(0, 0, 1, 0, 8'd0, 32'd0);

    // arm+trig together in IDLE, then trig with a matching sample.
    sel_ch = 8'd3; decim = 8'd0;
    cyc(1, 1, 0, 1, 8'd3, 32'h0000AAAA);
    check("same_no_write", 64'(bram_we), 64'd0);
    cyc(0, 1, 0, 1, 8'd3, 32'h5A5A0001);
    check("same_we", 64'(bram_we), 64'd1);
    check("same_addr", 64'(bram_addr), 64'd0);
    check("same_data", 64'(bram_wr_data), 64'h5A5A0001);

    // Mixed random control traffic.
    for (int i = 0; i < 3000; i++) begin
      sel_ch = 8'($urandom % 4); decim = 8'($urandom % 4);
      cyc(1'($urandom % 40 == 0), 1'($urandom % 8 == 0), 1'($urandom % 200 == 0),
          1'($urandom % 2), 8'($urandom % 4), $urandom);
    end

    // Asynchronous reset in the middle of a capture.
    cyc(0, 0, 1, 0, 8'd0, 32'd0);
    sel_ch = 8'd1; decim = 8'd0;
    cyc(1, 0, 0, 0, 8'd0, 32'd0);
    for (int i = 0; i < 20; i++) cyc(0, (i == 0) ? 1'b1 : 1'b0, 0, 1, 8'd1, 32'(i + 7));
    check("pre_rst_we", 64'(bram_we), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    check_all_zero("held_rst");
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 1, 8'd1, $urandom);
    check("post_rst_cnt", 64'(wr_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
